// File: rtl/spike_frame_deserializer_pkg.sv
// Shared definitions for the spike frame deserializer and the downstream
// per-channel processing units: FSM state encodings, the default frame-start
// marker, the words-per-frame derivation and the counter widths.
package spike_frame_deserializer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_FILL  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
  localparam int         FRAME_CNT_W   = 16;
  localparam int         GAP_W         = 16;

  // Input words per frame; the frame width must be a whole number of words.
  function automatic int calc_bpf(input int num_ch, input int sample_w, input int in_w);
    return (num_ch * sample_w) / in_w;
  endfunction

endpackage

// File: rtl/spike_frame_deserializer_gap_watchdog.sv
// Idle-cycle watchdog for a partially assembled frame.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : watchdog armed (frame partially filled)
//   kick      : a word was accepted this cycle; restarts the idle count
//   limit     : idle cycles allowed; 0 disables the watchdog
//   timeout   : combinational pulse in the cycle that reaches the limit
module spike_frame_deserializer_gap_watchdog
  import spike_frame_deserializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kick,
  input  logic [GAP_W-1:0] limit,
  output logic             timeout
);

  localparam logic [GAP_W-1:0] ONE = GAP_W'(1);

  logic [GAP_W-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!en || kick) begin
      idle_cnt <= '0;
    end else if (idle_cnt != '1) begin
      idle_cnt <= idle_cnt + ONE;
    end
  end

  // idle_cnt holds the idle cycles already elapsed, so the current idle
  // cycle is number idle_cnt+1; a kick in that same cycle suppresses it.
  assign timeout = en && !kick && (limit != '0) && (idle_cnt >= (limit - ONE));

endmodule

// File: rtl/spike_frame_deserializer.sv
// Word-stream to frame deserializer feeding the per-channel spike units.
// Collects BPF input words into an assembly register (word i at bits
// [i*IN_W +: IN_W]), then moves the frame into an output holding register
// presented with valid/ready. Optional sync-word hunting, gap watchdog,
// backpressure (BACKPRESSURE=1) or drop-on-overrun (BACKPRESSURE=0).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   s_data/s_valid/s_ready : input word stream
//   sync_en         : every frame preceded by SYNC_WORD (sampled at frame boundaries)
//   gap_timeout_in  : idle cycles allowed mid-frame, 0 disables
//   m_frame/m_valid/m_ready : output frame handshake
//   frame_cnt       : frames loaded into the holding register (wrapping)
//   err_overrun     : sticky, frame dropped (drop mode only)
//   err_gap         : sticky, partial frame discarded by the watchdog
//   clr_err         : synchronous clear of both sticky errors
module spike_frame_deserializer
  import spike_frame_deserializer_pkg::*;
#(
  parameter int              NUM_CH       = 8,
  parameter int              SAMPLE_W     = 16,
  parameter int              IN_W         = 8,
  parameter int              BACKPRESSURE = 1,
  parameter logic [IN_W-1:0] SYNC_WORD    = IN_W'(DEF_SYNC_WORD)
)
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_W-1:0]              s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         sync_en,
  input  logic [GAP_W-1:0]             gap_timeout_in,
  output logic [NUM_CH*SAMPLE_W-1:0]   m_frame,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [FRAME_CNT_W-1:0]       frame_cnt,
  output logic                         err_overrun,
  output logic                         err_gap,
  input  logic                         clr_err
);

  localparam int FRAME_W = NUM_CH * SAMPLE_W;
  localparam int BPF     = calc_bpf(NUM_CH, SAMPLE_W, IN_W);
  localparam int IDX_W   = (BPF > 1) ? $clog2(BPF) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPF - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t             state_q;
  state_t             state_nx;
  state_t             cur_st;
  state_t             boundary_st;
  logic               fresh_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_nx;
  logic [FRAME_W-1:0] asm_q;
  logic [FRAME_W-1:0] asm_nx;
  logic               accept;
  logic               hold_free;
  logic               store;
  logic               load;
  logic               set_ovr;
  logic               set_gap;
  logic               gap_en;
  logic               gap_timeout;

  // The reset value of the state depends on sync_en as seen at release, so
  // the first cycle after reset resolves HUNT/FILL from sync_en directly.
  assign cur_st      = fresh_q ? (sync_en ? ST_HUNT : ST_FILL) : state_q;
  assign boundary_st = sync_en ? ST_HUNT : ST_FILL;

  assign s_ready   = (BACKPRESSURE == 0) || (state_q != ST_STALL);
  assign accept    = s_valid && s_ready;
  assign hold_free = !m_valid || m_ready;
  assign gap_en    = (cur_st == ST_FILL) && (idx_q != '0);

  spike_frame_deserializer_gap_watchdog u_gap_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (gap_en),
    .kick    (accept),
    .limit   (gap_timeout_in),
    .timeout (gap_timeout)
  );

  always_comb begin
    state_nx = cur_st;
    idx_nx   = idx_q;
    store    = 1'b0;
    load     = 1'b0;
    set_ovr  = 1'b0;
    set_gap  = 1'b0;
    case (cur_st)
      ST_HUNT: begin
        if (accept && (s_data == SYNC_WORD)) begin
          state_nx = ST_FILL;
          idx_nx   = '0;
        end
      end
      ST_FILL: begin
        if (accept) begin
          store = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_nx = '0;
            if (hold_free) begin
              load     = 1'b1;
              state_nx = boundary_st;
            end else if (BACKPRESSURE != 0) begin
              state_nx = ST_STALL;
            end else begin
              set_ovr  = 1'b1;
              state_nx = boundary_st;
            end
          end else begin
            idx_nx = idx_q + IDX_ONE;
          end
        end else if (gap_timeout) begin
          idx_nx   = '0;
          set_gap  = 1'b1;
          state_nx = boundary_st;
        end
      end
      ST_STALL: begin
        if (hold_free) begin
          load     = 1'b1;
          state_nx = boundary_st;
        end
      end
      default: begin
        state_nx = boundary_st;
        idx_nx   = '0;
      end
    endcase
  end

  // Assembly word merge: the completing word goes straight into the frame
  // that loads the holding register in the same cycle.
  always_comb begin
    asm_nx = asm_q;
    if (store) begin
      asm_nx[int'(idx_q) * IN_W +: IN_W] = s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      fresh_q     <= 1'b1;
      idx_q       <= '0;
      m_valid     <= 1'b0;
      m_frame     <= '0;
      frame_cnt   <= '0;
      err_overrun <= 1'b0;
      err_gap     <= 1'b0;
    end else begin
      state_q <= state_nx;
      fresh_q <= 1'b0;
      idx_q   <= idx_nx;
      if (load) begin
        m_valid   <= 1'b1;
        m_frame   <= asm_nx;
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      err_overrun <= set_ovr | (err_overrun & ~clr_err);
      err_gap     <= set_gap | (err_gap & ~clr_err);
    end
  end

  // Assembly data carries no reset; idx and state decide what is meaningful.
  always_ff @(posedge clk) begin
    if (store) begin
      asm_q <= asm_nx;
    end
  end

endmodule

// File: tb/tb_spike_frame_deserializer.sv
// Self-checking bench: one backpressure instance (a) and one drop-mode
// instance (b) share the input stream; each is compared every cycle against
// a frame-level model (byte list, pending-frame slots, counters, flags).
module tb_spike_frame_deserializer;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        sync_en;
  logic [15:0] gap_timeout_in;
  logic        m_ready;
  logic        clr_err;

  logic        s_ready_a, s_ready_b;
  logic [63:0] m_frame_a, m_frame_b;
  logic        m_valid_a, m_valid_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;
  logic        err_overrun_a, err_overrun_b;
  logic        err_gap_a, err_gap_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model state, index 0 = backpressure instance, 1 = drop instance.
  int          widx  [2];
  bit          hunt  [2];
  logic [63:0] cur   [2];
  logic [63:0] h0    [2];
  logic [63:0] h1    [2];
  int          nh    [2];
  logic [15:0] fcnt  [2];
  bit          eov   [2];
  bit          egap  [2];
  int          idle  [2];

  spike_frame_deserializer #(
    .NUM_CH(4), .SAMPLE_W(16), .IN_W(8), .BACKPRESSURE(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
    .sync_en(sync_en), .gap_timeout_in(gap_timeout_in), .m_frame(m_frame_a),
    .m_valid(m_valid_a), .m_ready(m_ready), .frame_cnt(frame_cnt_a),
    .err_overrun(err_overrun_a), .err_gap(err_gap_a), .clr_err(clr_err)
  );

  spike_frame_deserializer #(
    .NUM_CH(4), .SAMPLE_W(16), .IN_W(8), .BACKPRESSURE(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
    .sync_en(sync_en), .gap_timeout_in(gap_timeout_in), .m_frame(m_frame_b),
    .m_valid(m_valid_b), .m_ready(m_ready), .frame_cnt(frame_cnt_b),
    .err_overrun(err_overrun_b), .err_gap(err_gap_b), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkframe(input logic [7:0] base);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[8*k +: 8] = base + 8'(k);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      widx[i] = 0; hunt[i] = sync_en; cur[i] = '0; h0[i] = '0; h1[i] = '0;
      nh[i] = 0; fcnt[i] = '0; eov[i] = 0; egap[i] = 0; idle[i] = 0;
    end
  endtask

  // One clock of the specification's behaviour for instance i.
  task automatic model_step(input int i, input bit bp);
    bit rdy, acc, drn, set_o, set_g;
    rdy   = !(bp && nh[i] == 2);
    acc   = s_valid && rdy;
    drn   = (nh[i] > 0) && m_ready;
    set_o = 0;
    set_g = 0;
    if (nh[i] == 2) begin
      if (drn) begin
        h0[i] = h1[i]; nh[i] = 1; fcnt[i] = fcnt[i] + 16'd1; hunt[i] = sync_en;
      end
    end else begin
      if (drn) nh[i] = 0;
      if (acc) begin
        idle[i] = 0;
        if (hunt[i]) begin
          if (s_data == 8'hA5) hunt[i] = 0;
        end else begin
          if (widx[i] == 0) cur[i] = '0;
          cur[i] = cur[i] | (64'(s_data) << (8 * widx[i]));
          widx[i]++;
          if (widx[i] == 8) begin
            widx[i] = 0;
            if (nh[i] == 0) begin
              h0[i] = cur[i]; nh[i] = 1; fcnt[i] = fcnt[i] + 16'd1; hunt[i] = sync_en;
            end else if (bp) begin
              h1[i] = cur[i]; nh[i] = 2;
            end else begin
              set_o = 1; hunt[i] = sync_en;
            end
          end
        end
      end else if (!hunt[i] && widx[i] > 0) begin
        idle[i]++;
        if (gap_timeout_in != 0 && idle[i] >= int'(gap_timeout_in)) begin
          widx[i] = 0; idle[i] = 0; set_g = 1; hunt[i] = sync_en;
        end
      end else begin
        idle[i] = 0;
      end
    end
    eov[i]  = set_o || (eov[i] && !clr_err);
    egap[i] = set_g || (egap[i] && !clr_err);
  endtask

  task automatic compare_all();
    chk("a_s_ready", 64'(s_ready_a), 64'(nh[0] < 2));
    chk("a_m_valid", 64'(m_valid_a), 64'(nh[0] != 0));
    if (nh[0] != 0) chk("a_m_frame", m_frame_a, h0[0]);
    chk("a_frame_cnt", 64'(frame_cnt_a), 64'(fcnt[0]));
    chk("a_err_overrun", 64'(err_overrun_a), 64'(eov[0]));
    chk("a_err_gap", 64'(err_gap_a), 64'(egap[0]));
    chk("b_s_ready", 64'(s_ready_b), 64'(1'b1));
    chk("b_m_valid", 64'(m_valid_b), 64'(nh[1] != 0));
    if (nh[1] != 0) chk("b_m_frame", m_frame_b, h0[1]);
    chk("b_frame_cnt", 64'(frame_cnt_b), 64'(fcnt[1]));
    chk("b_err_overrun", 64'(err_overrun_b), 64'(eov[1]));
    chk("b_err_gap", 64'(err_gap_b), 64'(egap[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      model_step(0, 1'b1);
      model_step(1, 1'b0);
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset(input bit sync, input logic [15:0] gap, input bit mr);
    s_valid = 0; s_data = '0; clr_err = 0;
    sync_en = sync; gap_timeout_in = gap; m_ready = mr;
    rst = 1;
    #1;
    model_reset();
    compare_all();
    chk("rst_m_valid_a", 64'(m_valid_a), 64'(0));
    chk("rst_m_frame_a", m_frame_a, 64'(0));
    chk("rst_m_frame_b", m_frame_b, 64'(0));
    chk("rst_frame_cnt_a", 64'(frame_cnt_a), 64'(0));
    chk("rst_s_ready_a", 64'(s_ready_a), 64'(1));
    repeat (2) cycle();
    @(negedge clk);
    rst = 0;
  endtask

  // Offer one byte until instance a takes it (b sees the same stream).
  task automatic send_a(input logic [7:0] b);
    int guard;
    bit took;
    guard = 0;
    s_valid = 1;
    s_data  = b;
    do begin
      took = s_ready_a;
      cycle();
      guard++;
    end while (!took && guard < 64);
    chk("send_bound", 64'(took), 64'(1));
    s_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int k = 0; k < 8; k++) send_a(base + 8'(k));
  endtask

  task automatic idle_cycles(input int n);
    s_valid = 0;
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1; s_valid = 0; s_data = '0; sync_en = 0;
    gap_timeout_in = '0; m_ready = 1; clr_err = 0;

    // 1: plain framing, back-to-back bytes
    do_reset(1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 7; k++) send_a(8'(k * 17));
    chk("t1_not_yet_valid", 64'(m_valid_a), 64'(0));
    send_a(8'h77);
    chk("t1_valid", 64'(m_valid_a), 64'(1));
    chk("t1_frame", m_frame_a, 64'h7766554433221100);
    chk("t1_cnt", 64'(frame_cnt_a), 64'(1));
    idle_cycles(2);

    // 2: sync-word framing
    do_reset(1'b1, 16'd0, 1'b1);
    send_a(8'h3C);
    send_a(8'hA5);
    for (int k = 1; k <= 8; k++) send_a(8'(k));
    chk("t2_frame", m_frame_a, 64'h0807060504030201);
    chk("t2_cnt", 64'(frame_cnt_a), 64'(1));
    idle_cycles(2);

    // 3: backpressure holds two frames and releases them in order
    do_reset(1'b0, 16'd0, 1'b0);
    send_frame(8'h10);
    send_frame(8'h20);
    chk("t3_stall_ready", 64'(s_ready_a), 64'(0));
    chk("t3_first_frame", m_frame_a, mkframe(8'h10));
    chk("t3_cnt1", 64'(frame_cnt_a), 64'(1));
    m_ready = 1;
    idle_cycles(1);
    m_ready = 0;
    chk("t3_second_frame", m_frame_a, mkframe(8'h20));
    chk("t3_cnt2", 64'(frame_cnt_a), 64'(2));
    send_frame(8'h30);
    chk("t3_stall_again", 64'(s_ready_a), 64'(0));
    m_ready = 1;
    idle_cycles(1);
    chk("t3_third_frame", m_frame_a, mkframe(8'h30));
    chk("t3_cnt3", 64'(frame_cnt_a), 64'(3));
    idle_cycles(1);
    chk("t3_drained", 64'(m_valid_a), 64'(0));

    // 4: drop mode overrun
    do_reset(1'b0, 16'd0, 1'b0);
    send_frame(8'h40);
    send_frame(8'h50);
    chk("t4_overrun", 64'(err_overrun_b), 64'(1));
    chk("t4_retained", m_frame_b, mkframe(8'h40));
    chk("t4_cnt", 64'(frame_cnt_b), 64'(1));
    chk("t4_bp_no_overrun", 64'(err_overrun_a), 64'(0));
    clr_err = 1;
    idle_cycles(1);
    clr_err = 0;
    chk("t4_overrun_cleared", 64'(err_overrun_b), 64'(0));

    // 5: gap watchdog
    do_reset(1'b0, 16'd5, 1'b1);
    send_a(8'h61); send_a(8'h62); send_a(8'h63);
    idle_cycles(4);
    chk("t5_gap_early", 64'(err_gap_a), 64'(0));
    idle_cycles(1);
    chk("t5_gap_a", 64'(err_gap_a), 64'(1));
    chk("t5_gap_b", 64'(err_gap_b), 64'(1));
    send_frame(8'h70);
    chk("t5_clean_frame", m_frame_a, mkframe(8'h70));
    clr_err = 1;
    idle_cycles(1);
    clr_err = 0;
    chk("t5_gap_cleared", 64'(err_gap_a), 64'(0));
    send_a(8'h80); send_a(8'h81); send_a(8'h82);
    idle_cycles(4);
    for (int k = 3; k < 8; k++) send_a(8'h80 + 8'(k));
    chk("t5_word_wins_gap", 64'(err_gap_a), 64'(0));
    chk("t5_word_wins_frame", m_frame_a, mkframe(8'h80));

    // 6: reset mid-frame and with a held frame
    do_reset(1'b0, 16'd0, 1'b1);
    for (int k = 0; k < 4; k++) send_a(8'hC0 + 8'(k));
    m_ready = 0;
    do_reset(1'b0, 16'd0, 1'b0);
    send_frame(8'hD0);
    chk("t6_held", 64'(m_valid_a), 64'(1));
    do_reset(1'b0, 16'd0, 1'b1);
    send_frame(8'h90);
    chk("t6_after_reset_frame", m_frame_a, mkframe(8'h90));
    chk("t6_after_reset_cnt", 64'(frame_cnt_a), 64'(1));
    idle_cycles(2);

    // Randomized traffic against the model
    for (int seg = 0; seg < 3; seg++) begin
      do_reset(seg != 0, (seg == 1) ? 16'd0 : 16'(4 - seg), 1'b1);
      for (int c = 0; c < 1500; c++) begin
        int r;
        r       = $urandom_range(0, 7);
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = (r == 0) ? 8'hA5 : 8'($urandom);
        m_ready = ($urandom_range(0, 2) != 0);
        clr_err = ($urandom_range(0, 15) == 0);
        cycle();
      end
      s_valid = 0;
      clr_err = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
